// File: rtl/dht11_emulator.sv
// DHT11 sensor emulator: answers a host start pulse on the open-drain
// single-wire bus with the response preamble, 40 data bits and a trailing
// low, exactly as a real DHT11 would. All times are in clk cycles.
module dht11_emulator #(
   parameter int unsigned T_START_MIN = 100000,
   parameter int unsigned T_WAIT      = 3000,
   parameter int unsigned T_RESP_LO   = 8000,
   parameter int unsigned T_RESP_HI   = 8000,
   parameter int unsigned T_BIT_LO    = 5000,
   parameter int unsigned T_ZERO_HI   = 2700,
   parameter int unsigned T_ONE_HI    = 7000,
   parameter int unsigned T_END_LO    = 5000,
   parameter int unsigned T_COOL      = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] hum_int,
   input  logic [7:0] hum_dec,
   input  logic [7:0] temp_int,
   input  logic [7:0] temp_dec,
   input  logic       csum_err_inj,
   inout  wire        dht_data,
   output logic       dht_oe,
   output logic       busy,
   output logic       frame_done
);

   typedef enum logic [3:0] {
      IDLE, START_LO, WAIT_REL, RESP_WAIT, RESP_LO,
      RESP_HI, BIT_LO, BIT_HI, END_LO, COOL
   } state_t;

   state_t      state;
   logic [31:0] cnt;
   logic [5:0]  bit_idx;
   logic [39:0] frame;
   logic        sync_a;
   logic        line_s;
   logic [7:0]  sum_raw;
   logic [7:0]  csum;
   logic        cur_bit;
   logic [31:0] hi_len;

   // Open-drain: only ever pull the wire low, otherwise leave it to the pull-up.
   assign dht_data = dht_oe ? 1'b0 : 1'bz;

   // Checksum wraps naturally in 8 bits; the inject input flips every bit.
   assign sum_raw = hum_int + hum_dec + temp_int + temp_dec;
   assign csum    = csum_err_inj ? ~sum_raw : sum_raw;

   // Bit currently on the wire (MSB of hum_int first) and its high-time.
   assign cur_bit = (bit_idx < 6'd40) ? frame[6'd39 - bit_idx] : 1'b0;
   assign hi_len  = cur_bit ? T_ONE_HI : T_ZERO_HI;

   // Two-flop synchronizer for the asynchronous bus; idles high like the wire.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a <= 1'b1;
         line_s <= 1'b1;
      end else begin
         sync_a <= dht_data;
         line_s <= sync_a;
      end
   end

   // Protocol sequencer: every output is registered and changes only on a state change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         frame      <= '0;
         dht_oe     <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else if (!en) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         dht_oe     <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (!line_s) begin
                  state <= START_LO;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            START_LO: begin
               if (line_s) begin
                  state <= IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else if (cnt >= T_START_MIN - 32'd1) begin
                  state <= WAIT_REL;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            WAIT_REL: begin
               if (line_s) begin
                  state <= RESP_WAIT;
                  cnt   <= '0;
               end
            end
            RESP_WAIT: begin
               if (cnt == T_WAIT - 32'd1) begin
                  state  <= RESP_LO;
                  cnt    <= '0;
                  frame  <= {hum_int, hum_dec, temp_int, temp_dec, csum};
                  dht_oe <= 1'b1;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            RESP_LO: begin
               if (cnt == T_RESP_LO - 32'd1) begin
                  state  <= RESP_HI;
                  cnt    <= '0;
                  dht_oe <= 1'b0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            RESP_HI: begin
               if (cnt == T_RESP_HI - 32'd1) begin
                  state   <= BIT_LO;
                  cnt     <= '0;
                  bit_idx <= '0;
                  dht_oe  <= 1'b1;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            BIT_LO: begin
               if (cnt == T_BIT_LO - 32'd1) begin
                  state  <= BIT_HI;
                  cnt    <= '0;
                  dht_oe <= 1'b0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            BIT_HI: begin
               if (cnt == hi_len - 32'd1) begin
                  state   <= (bit_idx == 6'd39) ? END_LO : BIT_LO;
                  cnt     <= '0;
                  bit_idx <= bit_idx + 6'd1;
                  dht_oe  <= 1'b1;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            END_LO: begin
               if (cnt == T_END_LO - 32'd1) begin
                  state      <= COOL;
                  cnt        <= '0;
                  dht_oe     <= 1'b0;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            COOL: begin
               if (cnt == T_COOL - 32'd1) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            default: begin
               state  <= IDLE;
               cnt    <= '0;
               dht_oe <= 1'b0;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dht11_emulator.sv
// Testbench for dht11_emulator: a host model drives start pulses on the
// open-drain bus, expected frames go into a scoreboard queue, and an
// independent monitor decodes the bus waveform whenever frame_done pulses.
`timescale 1ns/1ps
module tb_dht11_emulator;

   localparam int T_START_MIN = 200;
   localparam int T_WAIT      = 30;
   localparam int T_RESP_LO   = 80;
   localparam int T_RESP_HI   = 80;
   localparam int T_BIT_LO    = 50;
   localparam int T_ZERO_HI   = 27;
   localparam int T_ONE_HI    = 70;
   localparam int T_END_LO    = 50;
   localparam int T_COOL      = 1000;
   localparam int FRAME_BUDGET = 10000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [7:0] hum_int, hum_dec, temp_int, temp_dec;
   logic       csum_err_inj;
   logic       host_oe;
   wire        dht_data;
   logic       dht_oe, busy, frame_done;

   int checks_total  = 0;
   int checks_passed = 0;

   typedef struct {
      logic lvl;
      int   len;
   } run_t;

   logic [39:0] exp_q[$];
   run_t        runs[$];

   // Host side of the wire plus the external pull-up.
   assign dht_data = host_oe ? 1'b0 : 1'bz;
   pullup (dht_data);

   // 100 MHz clock.
   always #5 clk = ~clk;

   dht11_emulator #(
      .T_START_MIN(T_START_MIN), .T_WAIT(T_WAIT), .T_RESP_LO(T_RESP_LO),
      .T_RESP_HI(T_RESP_HI), .T_BIT_LO(T_BIT_LO), .T_ZERO_HI(T_ZERO_HI),
      .T_ONE_HI(T_ONE_HI), .T_END_LO(T_END_LO), .T_COOL(T_COOL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .hum_int(hum_int), .hum_dec(hum_dec), .temp_int(temp_int), .temp_dec(temp_dec),
      .csum_err_inj(csum_err_inj), .dht_data(dht_data),
      .dht_oe(dht_oe), .busy(busy), .frame_done(frame_done)
   );

   // Reference model: four data bytes followed by their sum mod 256 (or its complement).
   function automatic logic [39:0] model_frame(input logic [7:0] a, input logic [7:0] b,
                                               input logic [7:0] c, input logic [7:0] d,
                                               input logic inj);
      int s;
      int cs;
      s  = int'(a) + int'(b) + int'(c) + int'(d);
      cs = s % 256;
      if (inj) cs = 255 - cs;
      return {a, b, c, d, 8'(cs)};
   endfunction

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks_total++;
      if (actual === expected) checks_passed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Decode the last 83 line runs (response, 40 bits, trailing low) and score them.
   task automatic decode_frame();
      int          n;
      int          base;
      bit          timing_ok;
      logic [39:0] data;
      logic [39:0] exp_frame;
      run_t        r;
      n = runs.size();
      if (exp_q.size() == 0) begin
         check_output("unexpected_frame_done", 1, 0);
         return;
      end
      exp_frame = exp_q.pop_front();
      if (n < 83) begin
         check_output("frame_run_count", n, 83);
         return;
      end
      base = n - 83;
      timing_ok = 1'b1;
      data = '0;
      r = runs[base];
      if (r.lvl !== 1'b0 || r.len != T_RESP_LO) timing_ok = 1'b0;
      r = runs[base + 1];
      if (r.lvl !== 1'b1 || r.len != T_RESP_HI) timing_ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         r = runs[base + 2 + 2 * i];
         if (r.lvl !== 1'b0 || r.len != T_BIT_LO) timing_ok = 1'b0;
         r = runs[base + 3 + 2 * i];
         if (r.lvl !== 1'b1) timing_ok = 1'b0;
         if (r.len == T_ONE_HI) data = {data[38:0], 1'b1};
         else if (r.len == T_ZERO_HI) data = {data[38:0], 1'b0};
         else begin
            data = {data[38:0], 1'bx};
            timing_ok = 1'b0;
         end
      end
      r = runs[base + 82];
      if (r.lvl !== 1'b0 || r.len != T_END_LO) timing_ok = 1'b0;
      check_output("frame_timing", timing_ok, 1);
      check_output("frame_data", data, exp_frame);
   endtask

   // Monitor: run-length encode the bus every cycle and score a frame on each frame_done.
   initial begin : monitor
      logic lvl;
      logic prev_lvl;
      int   run_len;
      logic prev_fd;
      prev_lvl = 1'b1;
      run_len  = 0;
      prev_fd  = 1'b0;
      forever begin
         @(negedge clk);
         lvl = (dht_data === 1'b0) ? 1'b0 : 1'b1;
         if (lvl == prev_lvl) run_len++;
         else begin
            runs.push_back('{prev_lvl, run_len});
            if (runs.size() > 200) void'(runs.pop_front());
            prev_lvl = lvl;
            run_len  = 1;
         end
         if (prev_fd) check_output("frame_done_width", frame_done, 0);
         if (frame_done === 1'b1 && !prev_fd) decode_frame();
         prev_fd = (frame_done === 1'b1);
      end
   end

   // Host start pulse; optionally measure the response latency and/or queue the expected frame.
   task automatic apply_stimulus(input int low_cycles, input bit push, input bit measure);
      int n;
      host_oe = 1'b1;
      tick(low_cycles);
      host_oe = 1'b0;
      if (push) exp_q.push_back(model_frame(hum_int, hum_dec, temp_int, temp_dec, csum_err_inj));
      if (measure) begin
         n = 0;
         while (n < FRAME_BUDGET) begin
            @(posedge clk);
            #1;
            n++;
            if (dht_oe) break;
         end
         check_output("resp_latency", n, T_WAIT + 3);
         check_output("busy_in_frame", busy, 1);
      end
   endtask

   task automatic wait_oe_rises(input int count);
      int   seen;
      logic prev;
      bit   ok;
      seen = 0;
      ok   = 1'b0;
      prev = dht_oe;
      for (int c = 0; c < FRAME_BUDGET; c++) begin
         @(posedge clk);
         #1;
         if (dht_oe && !prev) seen++;
         prev = dht_oe;
         if (seen == count) begin
            ok = 1'b1;
            break;
         end
      end
      check_output("oe_rise_wait", ok, 1);
   endtask

   task automatic wait_frame_done_and_cool();
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < FRAME_BUDGET; c++) begin
         @(negedge clk);
         if (frame_done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      check_output("frame_done_wait", ok, 1);
      check_output("busy_in_cool", busy, 0);
      tick(T_COOL + 10);
   endtask

   task automatic watch_quiet(input string name, input int n);
      bit seen;
      seen = 1'b0;
      repeat (n) begin
         @(negedge clk);
         if (dht_oe !== 1'b0) seen = 1'b1;
      end
      check_output(name, seen, 0);
   endtask

   task automatic set_inputs(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d, input logic inj);
      hum_int = a; hum_dec = b; temp_int = c; temp_dec = d; csum_err_inj = inj;
   endtask

   task automatic full_frame();
      apply_stimulus(600, 1'b1, 1'b1);
      wait_frame_done_and_cool();
   endtask

   // Watchdog so the run can never hang.
   initial begin
      #1_500_000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence.
   initial begin
      rst_n = 1'b0;
      en = 1'b1;
      host_oe = 1'b0;
      set_inputs(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      tick(3);
      check_output("reset_oe", dht_oe, 0);
      check_output("reset_busy", busy, 0);
      check_output("reset_frame_done", frame_done, 0);
      check_output("reset_bus_high", dht_data, 1);
      rst_n = 1'b1;
      tick(5);

      $display("[TB] nominal frame 37/00/17/00");
      set_inputs(8'h37, 8'h00, 8'h17, 8'h00, 1'b0);
      full_frame();

      $display("[TB] short host pulse");
      apply_stimulus(50, 1'b0, 1'b0);
      watch_quiet("short_pulse_no_resp", T_WAIT + T_RESP_LO + 200);
      check_output("short_pulse_busy", busy, 0);

      $display("[TB] checksum wrap and injected error");
      set_inputs(8'hFF, 8'hFF, 8'h01, 8'h02, 1'b0);
      full_frame();
      set_inputs(8'h37, 8'h00, 8'h17, 8'h00, 1'b1);
      full_frame();

      $display("[TB] input change during bit 3");
      set_inputs(8'h37, 8'h00, 8'h17, 8'h00, 1'b0);
      apply_stimulus(600, 1'b1, 1'b1);
      wait_oe_rises(4);
      hum_int = 8'h50;
      temp_dec = 8'hA5;
      wait_frame_done_and_cool();

      $display("[TB] enable dropped during bit 20");
      set_inputs(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
      apply_stimulus(600, 1'b0, 1'b1);
      wait_oe_rises(21);
      en = 1'b0;
      tick(1);
      check_output("en_release_oe", dht_oe, 0);
      check_output("en_release_busy", busy, 0);
      tick(20);
      en = 1'b1;
      tick(5);
      set_inputs(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
      full_frame();

      $display("[TB] reset pulsed during response low");
      apply_stimulus(600, 1'b0, 1'b1);
      tick(10);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("rst_async_oe", dht_oe, 0);
      check_output("rst_bus_high", dht_data, 1);
      tick(3);
      rst_n = 1'b1;
      watch_quiet("rst_no_resume", T_WAIT + T_RESP_LO + 200);
      set_inputs(8'h37, 8'h00, 8'h17, 8'h00, 1'b0);
      apply_stimulus(600, 1'b1, 1'b1);
      wait_frame_done_and_cool();

      $display("[TB] start issued during cool-down");
      apply_stimulus(400, 1'b1, 1'b1);
      begin : cool_case
         bit ok;
         ok = 1'b0;
         for (int c = 0; c < FRAME_BUDGET; c++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
               ok = 1'b1;
               break;
            end
         end
         check_output("frame_done_wait", ok, 1);
      end
      tick(100);
      host_oe = 1'b1;
      tick(300);
      host_oe = 1'b0;
      watch_quiet("cool_start_ignored", T_COOL + T_WAIT + 100);
      check_output("cool_start_busy", busy, 0);

      $display("[TB] randomized frames");
      for (int i = 0; i < 3; i++) begin
         set_inputs(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)));
         full_frame();
      end

      check_output("frames_outstanding", exp_q.size(), 0);
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
